pc_offload_ctrl: RTL and testbench

//  Next-PC sequencer in front of the PC register. Each cycle it picks the next fetch PC (stall, branch or sequential) and drives the PC hold line.
//  On fetching the trigger PC it freezes fetch, flushes the front end, launches the CGRA, waits for completion and redirects fetch to the resume PC.

---
 rtl/pc_offload_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pc_offload_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_offload_ctrl.sv
// pc_offload_ctrl
//   Next-PC sequencer that sits in front of the PC register. It normally
//   chooses between stall, branch target and sequential PC. When the fetch PC
//   equals TRIG_PC it freezes fetch, flushes the front end, starts the CGRA,
//   waits for it to finish and then redirects fetch to RESUME_PC.
//
//   Optional feature macro: PC_OFFLOAD_TIMEOUT_EN
//     defined   : a 16-bit WAIT watchdog aborts the offload after TIMEOUT
//                 WAIT cycles without completion and sets the sticky err_o.
//     undefined : WAIT waits for completion forever, err_o is tied low.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   pc_i           current PC (PC register output)
//   hazard_i       load-use hazard
//   branch_i       taken branch/jump resolved this cycle
//   branch_tgt_i   branch/jump target
//   cgra_ready_i   CGRA idle and able to accept a start
//   cgra_done_i    CGRA completion pulse
//   pc_next_o      next PC
//   pc_hold_o      hold the PC register
//   flush_o        flush IF/ID
//   cgra_start_o   registered one-cycle CGRA start pulse
//   offload_busy_o high in every state except RUN
//   offload_cnt_o  completed offloads, wraps 255 -> 0
//   err_o          sticky watchdog abort flag
module pc_offload_ctrl #(
    parameter logic [31:0] TRIG_PC   = 32'd200,
    parameter logic [31:0] RESUME_PC = 32'd248,
    parameter logic [15:0] TIMEOUT   = 16'd1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        hazard_i,
    input  logic        branch_i,
    input  logic [31:0] branch_tgt_i,
    input  logic        cgra_ready_i,
    input  logic        cgra_done_i,
    output logic [31:0] pc_next_o,
    output logic        pc_hold_o,
    output logic        flush_o,
    output logic        cgra_start_o,
    output logic        offload_busy_o,
    output logic [7:0]  offload_cnt_o,
    output logic        err_o
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESUME = 2'd3;

    logic [1:0] state_reg, state_next;
    logic       armed_reg, armed_next;
    logic       start_reg, start_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       wd_expired;

    always_comb begin
        state_next = state_reg;
        armed_next = armed_reg;
        start_next = 1'b0;
        cnt_next   = cnt_reg;
        pc_next_o  = pc_i;
        pc_hold_o  = 1'b0;
        flush_o    = 1'b0;
        case (state_reg)
            ST_RUN: begin
                // Re-arm only once fetch has moved off the trigger PC, so a
                // resume landing on TRIG_PC cannot immediately retrigger.
                if (pc_i != TRIG_PC) begin
                    armed_next = 1'b1;
                end
                if (branch_i) begin
                    pc_next_o = branch_tgt_i;
                    flush_o   = 1'b1;
                end else if (hazard_i) begin
                    pc_hold_o = 1'b1;
                end else if (pc_i == TRIG_PC && armed_reg) begin
                    state_next = ST_REQ;
                    pc_hold_o  = 1'b1;
                    flush_o    = 1'b1;
                    armed_next = 1'b0;
                end else begin
                    pc_next_o = pc_i + 32'd4;
                end
            end
            ST_REQ: begin
                pc_hold_o = 1'b1;
                if (cgra_ready_i) begin
                    start_next = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                pc_hold_o = 1'b1;
                // Completion wins over a simultaneous watchdog expiry.
                if (cgra_done_i) begin
                    state_next = ST_RESUME;
                    cnt_next   = cnt_reg + 8'd1;
                end else if (wd_expired) begin
                    state_next = ST_RESUME;
                end
            end
            default: begin
                pc_next_o  = RESUME_PC;
                flush_o    = 1'b1;
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_RUN;
            armed_reg <= 1'b1;
            start_reg <= 1'b0;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            armed_reg <= armed_next;
            start_reg <= start_next;
            cnt_reg   <= cnt_next;
        end
    end

`ifdef PC_OFFLOAD_TIMEOUT_EN
    logic [15:0] wd_reg;
    logic        err_reg;

    // Counter is zero on the first WAIT cycle, so expiry at TIMEOUT-1
    // leaves exactly TIMEOUT WAIT cycles before RESUME.
    assign wd_expired = (state_reg == ST_WAIT) && (wd_reg == TIMEOUT - 16'd1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_reg  <= 16'd0;
            err_reg <= 1'b0;
        end else begin
            if (state_reg == ST_WAIT) begin
                wd_reg <= wd_reg + 16'd1;
            end else begin
                wd_reg <= 16'd0;
            end
            if (wd_expired && !cgra_done_i) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err_o = err_reg;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign wd_expired     = 1'b0;
    assign err_o          = 1'b0;
`endif

    assign cgra_start_o   = start_reg;
    assign offload_cnt_o  = cnt_reg;
    assign offload_busy_o = (state_reg != ST_RUN);

endmodule

// File: tb/tb_pc_offload_ctrl.sv
// Bench for pc_offload_ctrl. Two instances share the stimulus: u_dut uses
// the default trigger/resume PCs with an 8-cycle watchdog limit, u_dut5 uses
// RESUME_PC == TRIG_PC to exercise the no-retrigger rule. Each is held in
// reset while the other is under test; sel picks which one is compared.
module tb_pc_offload_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic        haz;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        done;
        logic [31:0] nxt;
        logic        hold;
        logic        flush;
        logic        start;
        logic        busy;
        logic [7:0]  cnt;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        sel = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        hazard = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] tgt = 32'd0;
    logic        ready = 1'b0;
    logic        done = 1'b0;

    logic [31:0] a_next, b_next;
    logic        a_hold, b_hold, a_flush, b_flush, a_start, b_start;
    logic        a_busy, b_busy, a_err, b_err;
    logic [7:0]  a_cnt, b_cnt;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];

    always #5 clk = ~clk;

    pc_offload_ctrl #(.TRIG_PC(32'd200), .RESUME_PC(32'd248), .TIMEOUT(16'd8)) u_dut (
        .clk_i(clk), .rst_i(rst_a), .pc_i(pc), .hazard_i(hazard), .branch_i(branch),
        .branch_tgt_i(tgt), .cgra_ready_i(ready), .cgra_done_i(done),
        .pc_next_o(a_next), .pc_hold_o(a_hold), .flush_o(a_flush), .cgra_start_o(a_start),
        .offload_busy_o(a_busy), .offload_cnt_o(a_cnt), .err_o(a_err)
    );

    pc_offload_ctrl #(.TRIG_PC(32'd200), .RESUME_PC(32'd200), .TIMEOUT(16'd8)) u_dut5 (
        .clk_i(clk), .rst_i(rst_b), .pc_i(pc), .hazard_i(hazard), .branch_i(branch),
        .branch_tgt_i(tgt), .cgra_ready_i(ready), .cgra_done_i(done),
        .pc_next_o(b_next), .pc_hold_o(b_hold), .flush_o(b_flush), .cgra_start_o(b_start),
        .offload_busy_o(b_busy), .offload_cnt_o(b_cnt), .err_o(b_err)
    );

    function automatic vec_t mk(input logic [31:0] p, input logic h, input logic b,
                                input logic [31:0] t, input logic r, input logic d,
                                input logic [31:0] n, input logic eh, input logic ef,
                                input logic es, input logic eb, input logic [7:0] ec,
                                input logic ee);
        vec_t v;
        v.pc = p; v.haz = h; v.br = b; v.tgt = t; v.rdy = r; v.done = d;
        v.nxt = n; v.hold = eh; v.flush = ef; v.start = es; v.busy = eb;
        v.cnt = ec; v.err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s got %0h want %0h", name, field, act, want);
        end
    endtask

    task automatic compare(input string name);
        vec_t e;
        e = exp_q.pop_front();
        chk(name, "next",  sel ? b_next  : a_next,  e.nxt);
        chk(name, "hold",  {31'd0, sel ? b_hold  : a_hold},  {31'd0, e.hold});
        chk(name, "flush", {31'd0, sel ? b_flush : a_flush}, {31'd0, e.flush});
        chk(name, "start", {31'd0, sel ? b_start : a_start}, {31'd0, e.start});
        chk(name, "busy",  {31'd0, sel ? b_busy  : a_busy},  {31'd0, e.busy});
        chk(name, "cnt",   {24'd0, sel ? b_cnt   : a_cnt},   {24'd0, e.cnt});
        chk(name, "err",   {31'd0, sel ? b_err   : a_err},   {31'd0, e.err});
    endtask

    // Called at a negedge: drive inputs, queue the expectation, compare once
    // the combinational outputs settle, then advance one full clock.
    task automatic step(input vec_t v, input string name);
        pc = v.pc; hazard = v.haz; branch = v.br; tgt = v.tgt;
        ready = v.rdy; done = v.done;
        exp_q.push_back(v);
        #1;
        compare(name);
        @(negedge clk);
        $display("step %-10s pc=%0d next=%0d hold=%b flush=%b start=%b busy=%b cnt=%0d err=%b",
                 name, v.pc, sel ? b_next : a_next, v.hold, v.flush, v.start, v.busy, v.cnt, v.err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];
        logic [7:0] cnt_e;

        // Sequential / branch / hazard vectors, all in RUN.
        tbl[0] = mk(32'd0,   0, 0, 0,      0, 0, 32'd4,   0, 0, 0, 0, 0, 0);
        tbl[1] = mk(32'd16,  0, 0, 0,      0, 0, 32'd20,  0, 0, 0, 0, 0, 0);
        tbl[2] = mk(32'd16,  1, 0, 0,      0, 0, 32'd16,  1, 0, 0, 0, 0, 0);
        tbl[3] = mk(32'd16,  1, 1, 32'd64, 0, 0, 32'd64,  0, 1, 0, 0, 0, 0);
        tbl[4] = mk(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 32'd0,  0, 0, 0, 0, 0, 0);
        tbl[5] = mk(32'd200, 0, 1, 32'd100, 1, 0, 32'd100, 0, 1, 0, 0, 0, 0);
        tbl[6] = mk(32'd200, 1, 0, 0,      1, 0, 32'd200, 1, 0, 0, 0, 0, 0);
        tbl[7] = mk(32'd100, 0, 0, 0,      0, 1, 32'd104, 0, 0, 0, 0, 0, 0);

        // Reset for two clocks with pc=0.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;

        for (int i = 0; i < 8; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Offload: trigger, REQ with ready, start pulse, done 5 clks later.
        step(mk(200, 0, 0, 0, 1, 0, 200, 1, 1, 0, 0, 0, 0), "t3_trig");
        step(mk(200, 0, 0, 0, 1, 0, 200, 1, 0, 0, 1, 0, 0), "t3_req");
        for (int k = 1; k <= 5; k++)
            step(mk(200, 0, 0, 0, 0, 0, 200, 1, 0, k == 1, 1, 0, 0), "t3_wait");
        step(mk(200, 0, 0, 0, 0, 1, 200, 1, 0, 0, 1, 0, 0), "t3_done");
        step(mk(200, 0, 0, 0, 0, 0, 248, 0, 1, 0, 1, 1, 0), "t3_resume");
        step(mk(248, 0, 0, 0, 0, 0, 252, 0, 0, 0, 0, 1, 0), "t3_run");

        // Ready late; done outside WAIT ignored; done with the start pulse accepted.
        step(mk(200, 0, 0, 0, 0, 0, 200, 1, 1, 0, 0, 1, 0), "t4_trig");
        step(mk(200, 0, 0, 0, 0, 1, 200, 1, 0, 0, 1, 1, 0), "t4_req0");
        step(mk(200, 1, 1, 64, 0, 0, 200, 1, 0, 0, 1, 1, 0), "t4_req1");
        step(mk(200, 0, 0, 0, 0, 0, 200, 1, 0, 0, 1, 1, 0), "t4_req2");
        step(mk(200, 0, 0, 0, 1, 0, 200, 1, 0, 0, 1, 1, 0), "t4_rdy");
        step(mk(200, 0, 0, 0, 0, 1, 200, 1, 0, 1, 1, 1, 0), "t4_start");
        step(mk(200, 0, 0, 0, 0, 0, 248, 0, 1, 0, 1, 2, 0), "t4_resume");
        step(mk(8,   0, 0, 0, 0, 0, 12,  0, 0, 0, 0, 2, 0), "t4_run");

        // Long WAIT: watchdog abort when enabled, otherwise keeps waiting.
        step(mk(200, 0, 0, 0, 1, 0, 200, 1, 1, 0, 0, 2, 0), "t6_trig");
        step(mk(200, 0, 0, 0, 1, 0, 200, 1, 0, 0, 1, 2, 0), "t6_req");
        for (int k = 1; k <= 8; k++)
            step(mk(200, 0, 0, 0, 0, 0, 200, 1, 0, k == 1, 1, 2, 0), "t6_wait");
`ifdef PC_OFFLOAD_TIMEOUT_EN
        step(mk(200, 0, 0, 0, 0, 0, 248, 0, 1, 0, 1, 2, 1), "t6_abort");
        cnt_e = 8'd2;
        step(mk(248, 0, 0, 0, 0, 0, 252, 0, 0, 0, 0, cnt_e, 1), "t6_run");
`else
        for (int k = 0; k < 12; k++)
            step(mk(200, 0, 0, 0, 0, 0, 200, 1, 0, 0, 1, 2, 0), "t6_more");
        step(mk(200, 0, 0, 0, 0, 1, 200, 1, 0, 0, 1, 2, 0), "t6_done");
        step(mk(200, 0, 0, 0, 0, 0, 248, 0, 1, 0, 1, 3, 0), "t6_resume");
        cnt_e = 8'd3;
        step(mk(248, 0, 0, 0, 0, 0, 252, 0, 0, 0, 0, cnt_e, 0), "t6_run");
`endif

        // Reset mid-WAIT aborts silently.
        step(mk(200, 0, 0, 0, 1, 0, 200, 1, 1, 0, 0, cnt_e, a_err), "rw_trig");
        step(mk(200, 0, 0, 0, 1, 0, 200, 1, 0, 0, 1, cnt_e, a_err), "rw_req");
        step(mk(200, 0, 0, 0, 0, 0, 200, 1, 0, 1, 1, cnt_e, a_err), "rw_wait");
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        step(mk(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0), "rw_after");

`ifdef PC_OFFLOAD_TIMEOUT_EN
        // Done on the expiry cycle counts as success.
        step(mk(200, 0, 0, 0, 1, 0, 200, 1, 1, 0, 0, 0, 0), "ex_trig");
        step(mk(200, 0, 0, 0, 1, 0, 200, 1, 0, 0, 1, 0, 0), "ex_req");
        for (int k = 1; k <= 7; k++)
            step(mk(200, 0, 0, 0, 0, 0, 200, 1, 0, k == 1, 1, 0, 0), "ex_wait");
        step(mk(200, 0, 0, 0, 0, 1, 200, 1, 0, 0, 1, 0, 0), "ex_done");
        step(mk(200, 0, 0, 0, 0, 0, 248, 0, 1, 0, 1, 1, 0), "ex_resume");
`endif

        // No retrigger when resuming at the trigger PC (second instance).
        sel = 1'b1; rst_a = 1'b1; rst_b = 1'b0;
        step(mk(200, 0, 0, 0, 1, 0, 200, 1, 1, 0, 0, 0, 0), "t5_trig");
        step(mk(200, 0, 0, 0, 1, 0, 200, 1, 0, 0, 1, 0, 0), "t5_req");
        step(mk(200, 0, 0, 0, 0, 1, 200, 1, 0, 1, 1, 0, 0), "t5_wait");
        step(mk(200, 0, 0, 0, 0, 0, 200, 0, 1, 0, 1, 1, 0), "t5_resume");
        for (int k = 0; k < 3; k++)
            step(mk(200, 0, 0, 0, 1, 0, 204, 0, 0, 0, 0, 1, 0), "t5_noretrig");
        step(mk(204, 0, 0, 0, 1, 0, 208, 0, 0, 0, 0, 1, 0), "t5_rearm");
        step(mk(200, 0, 0, 0, 1, 0, 200, 1, 1, 0, 0, 1, 0), "t5_retrig");
        step(mk(200, 0, 0, 0, 1, 0, 200, 1, 0, 0, 1, 1, 0), "t5_req2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
